ex_weights_fetch_ctrl: RTL and testbench

Sequencer that streams a block of weights out of one `EX_Weigths_Mem_Seg` segment into the EX datapath. It sits directly downstream of the segment. It drives the segment's `en`/`rd`/`index` port, absorbs the segment's one-cycle registered read latency, and presents the weights on a valid/ready stream. A small skid FIFO lets the stream sustain one weight per cycle while tolerating arbitrary backpressure.

---
 rtl/ex_pkg.sv | 13 +
 rtl/ex_wfetch_skid_fifo.sv | 42 ++++
 rtl/ex_weights_fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_ex_weights_fetch_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared EX constants: weight-fetch FSM encodings, default segment geometry
// and skid FIFO depth.
package ex_pkg;
  localparam int EX_HEIGHT      = 32;
  localparam int EX_BITSIZE     = 14;
  localparam int EX_IDXW        = 10;
  localparam int EX_WFIFO_DEPTH = 2;

  typedef logic [1:0] wf_state_t;
  localparam wf_state_t WF_IDLE  = 2'd0;
  localparam wf_state_t WF_FETCH = 2'd1;
  localparam wf_state_t WF_DRAIN = 2'd2;
endpackage

// File: rtl/ex_wfetch_skid_fifo.sv
// Two-entry skid FIFO for the weight stream; head is visible combinationally
// and occupancy is exported so the issuer can gate reads.
module ex_wfetch_skid_fifo
  import ex_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic [1:0]   occ
);
  logic [EX_WFIFO_DEPTH-1:0][W-1:0] mem;
  logic wp, rp;
  logic do_push, do_pop, full;

  assign empty   = (occ == 2'd0);
  assign full    = (occ == 2'(EX_WFIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
      wp  <= 1'b0;
      rp  <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/ex_weights_fetch_ctrl.sv
// Streams a block of weights out of one weight-memory segment onto a valid/ready
// stream. Optional w_zero output is enabled by EX_WFETCH_ZERO_FLAG_EN.
module ex_weights_fetch_ctrl
  import ex_pkg::*;
#(
  parameter int HEIGHT  = EX_HEIGHT,
  parameter int BITSIZE = EX_BITSIZE,
  parameter int IDXW    = EX_IDXW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IDXW-1:0]           base_addr,
  input  logic [IDXW:0]             count,
  output logic                      mem_en,
  output logic                      mem_rd,
  output logic [IDXW-1:0]           mem_index,
  input  logic [BITSIZE-1:0]        mem_data,
  output logic                      w_valid,
  input  logic                      w_ready,
  output logic signed [BITSIZE-1:0] w_data,
  output logic                      w_last,
  output logic                      busy,
  output logic                      done
`ifdef EX_WFETCH_ZERO_FLAG_EN
  ,
  output logic                      w_zero
`endif
);
`ifdef EX_WFETCH_ZERO_FLAG_EN
  localparam int PW = BITSIZE + 2;
`else
  localparam int PW = BITSIZE + 1;
`endif

  wf_state_t       state;
  logic [IDXW:0]   issued, cnt;
  logic [IDXW-1:0] rd_idx;
  logic            inflight, inflight_last, done_q;
  logic [1:0]      occ;
  logic            fifo_empty, pop, issue, issue_last;
  logic [PW-1:0]   push_data, head;

  assign pop = w_valid & w_ready;

  // Occupancy after this cycle's pop plus the read already in flight must
  // leave a slot for the word this read returns.
  assign issue = (state == WF_FETCH) && (issued < cnt) &&
                 (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  assign issue_last = issue && ((issued + (IDXW+1)'(1)) == cnt);

  assign mem_en    = issue;
  assign mem_rd    = issue;
  assign mem_index = rd_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= WF_IDLE;
      issued        <= '0;
      cnt           <= '0;
      rd_idx        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue_last;
      case (state)
        WF_IDLE: begin
          // done_q high means busy is still asserted, so start is ignored
          if (start && !done_q) begin
            if (count == '0) begin
              done_q <= 1'b1;
            end else begin
              state  <= WF_FETCH;
              issued <= '0;
              cnt    <= count;
              rd_idx <= base_addr;
            end
          end
        end
        WF_FETCH: begin
          if (issue) begin
            issued <= issued + (IDXW+1)'(1);
            rd_idx <= (rd_idx == IDXW'(HEIGHT-1)) ? '0 : rd_idx + IDXW'(1);
            if (issue_last) state <= WF_DRAIN;
          end
        end
        WF_DRAIN: begin
          if (pop && w_last) begin
            state  <= WF_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= WF_IDLE;
      endcase
    end
  end

`ifdef EX_WFETCH_ZERO_FLAG_EN
  assign push_data = {(mem_data == '0), mem_data, inflight_last};
  assign w_zero    = head[PW-1] & w_valid;
`else
  assign push_data = {mem_data, inflight_last};
`endif

  ex_wfetch_skid_fifo #(.W(PW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .occ   (occ)
  );

  assign w_valid = ~fifo_empty;
  assign w_data  = head[BITSIZE:1];
  assign w_last  = head[0] & w_valid;
  assign done    = done_q;
  assign busy    = (state != WF_IDLE) | done_q;
endmodule

// File: tb/tb_ex_weights_fetch_ctrl.sv
// Directed bench for ex_weights_fetch_ctrl with a registered-read segment model
// and a negedge monitor for read gating, stall stability and received beats.
module tb_ex_weights_fetch_ctrl;
  logic               clk = 1'b0;
  logic               rst, start, w_ready;
  logic [9:0]         base_addr;
  logic [10:0]        count;
  logic               mem_en, mem_rd;
  logic [9:0]         mem_index;
  logic signed [13:0] mem_data = '0;
  logic               w_valid, w_last, busy, done;
  logic signed [13:0] w_data;
`ifdef EX_WFETCH_ZERO_FLAG_EN
  logic               w_zero;
`endif

  logic signed [13:0] seg [0:31];
  int nchecks = 0, nfail = 0;
  int outstanding = 0, nrd = 0;
  logic [9:0]         idx_q [$];
  logic signed [13:0] rx_d [$];
  logic               rx_l [$];
  logic               prev_stall = 1'b0;
  logic signed [13:0] prev_data = '0;

  ex_weights_fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .mem_en(mem_en), .mem_rd(mem_rd), .mem_index(mem_index), .mem_data(mem_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .busy(busy), .done(done)
`ifdef EX_WFETCH_ZERO_FLAG_EN
    , .w_zero(w_zero)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en && mem_rd) mem_data <= seg[mem_index[4:0]];

  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      nchecks++;
      if (mem_rd !== mem_en) begin nfail++; $display("FAIL en_eq_rd: en=%b rd=%b", mem_en, mem_rd); end
      if (mem_rd) begin
        nchecks++;
        if (outstanding - int'(w_valid & w_ready) >= 2) begin
          nfail++; $display("FAIL read_gate: outstanding=%0d with read, must be below 2", outstanding);
        end
        nrd++;
        idx_q.push_back(mem_index);
      end
      if (prev_stall) begin
        nchecks++;
        if (w_valid !== 1'b1 || w_data !== prev_data) begin
          nfail++; $display("FAIL stall_hold: valid=%b data=%0d want 1/%0d", w_valid, w_data, prev_data);
        end
      end
`ifdef EX_WFETCH_ZERO_FLAG_EN
      nchecks++;
      if (w_zero !== (w_valid && w_data == 0)) begin nfail++; $display("FAIL w_zero: got %b", w_zero); end
`endif
      if (w_valid && w_ready) begin rx_d.push_back(w_data); rx_l.push_back(w_last); end
      outstanding = outstanding + int'(mem_rd) - int'(w_valid & w_ready);
      prev_stall  = w_valid & ~w_ready;
      prev_data   = w_data;
    end
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic clear_log();
    idx_q.delete(); rx_d.delete(); rx_l.delete(); nrd = 0;
  endtask

  task automatic kick(input logic [9:0] b, input logic [10:0] c);
    start = 1'b1; base_addr = b; count = c;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; w_ready = 1'b0; base_addr = '0; count = '0;
    repeat (2) @(negedge clk);
    nchecks++; if (mem_en !== 1'b0 || mem_rd !== 1'b0) begin nfail++; $display("FAIL rst_mem: en=%b rd=%b want 0", mem_en, mem_rd); end
    nchecks++; if (w_valid !== 1'b0 || w_last !== 1'b0) begin nfail++; $display("FAIL rst_stream: v=%b l=%b want 0", w_valid, w_last); end
    nchecks++; if (busy !== 1'b0 || done !== 1'b0) begin nfail++; $display("FAIL rst_status: busy=%b done=%b want 0", busy, done); end
    nchecks++; if (mem_index !== 10'd0) begin nfail++; $display("FAIL rst_index: got %0d want 0", mem_index); end
    nchecks++; if (w_data !== 14'sd0) begin nfail++; $display("FAIL rst_data: got %0d want 0", w_data); end
    step(); rst = 1'b0; step();
  endtask

  task automatic test_basic();
    logic signed [13:0] exp [4];
    exp = '{14'sd5, -14'sd3, 14'sd0, 14'sd7};
    clear_log(); w_ready = 1'b1;
    kick(10'd0, 11'd4);
    @(negedge clk);
    nchecks++; if (mem_rd !== 1'b1 || mem_index !== 10'd0) begin nfail++; $display("FAIL basic_first_rd: rd=%b idx=%0d want 1/0", mem_rd, mem_index); end
    nchecks++; if (busy !== 1'b1) begin nfail++; $display("FAIL basic_busy: got %b want 1", busy); end
    @(negedge clk);
    nchecks++; if (w_valid !== 1'b0) begin nfail++; $display("FAIL basic_early_valid: got %b want 0", w_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nchecks++;
      if (w_valid !== 1'b1 || w_data !== exp[i] || w_last !== (i == 3)) begin
        nfail++; $display("FAIL basic_beat%0d: v=%b d=%0d l=%b want 1/%0d/%b", i, w_valid, w_data, w_last, exp[i], i == 3);
      end
    end
    @(negedge clk);
    nchecks++; if (done !== 1'b1 || busy !== 1'b1 || w_valid !== 1'b0) begin nfail++; $display("FAIL basic_done: done=%b busy=%b v=%b want 1/1/0", done, busy, w_valid); end
    @(negedge clk);
    nchecks++; if (done !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL basic_idle: done=%b busy=%b want 0/0", done, busy); end
    nchecks++; if (nrd != 4) begin nfail++; $display("FAIL basic_nrd: got %0d want 4", nrd); end
    step();
  endtask

  task automatic test_wrap();
    bit ok;
    logic [9:0] ei [4];
    logic signed [13:0] ed [4];
    ei = '{10'd30, 10'd31, 10'd0, 10'd1};
    ed = '{14'sd230, 14'sd241, 14'sd5, -14'sd3};
    clear_log(); w_ready = 1'b1;
    kick(10'd30, 11'd4);
    wait_done(ok);
    nchecks++; if (!ok) begin nfail++; $display("FAIL wrap_timeout: done not seen"); end
    nchecks++;
    if (idx_q.size() != 4 || rx_d.size() != 4) begin
      nfail++; $display("FAIL wrap_count: reads=%0d beats=%0d want 4/4", idx_q.size(), rx_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nchecks++;
        if (idx_q[i] !== ei[i] || rx_d[i] !== ed[i] || rx_l[i] !== (i == 3)) begin
          nfail++; $display("FAIL wrap_beat%0d: idx=%0d d=%0d l=%b want %0d/%0d/%b", i, idx_q[i], rx_d[i], rx_l[i], ei[i], ed[i], i == 3);
        end
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    bit ok = 1'b0;
    clear_log();
    w_ready = 1'b0;
    kick(10'd8, 11'd6);
    for (int i = 0; i < 80; i++) begin
      if (i >= 3 && i <= 7) w_ready = 1'b0;
      else if (i >= 20)     w_ready = 1'b1;
      else                  w_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      step();
    end
    nchecks++; if (!ok) begin nfail++; $display("FAIL bp_timeout: done not seen"); end
    nchecks++;
    if (rx_d.size() != 6) begin
      nfail++; $display("FAIL bp_count: beats=%0d want 6", rx_d.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        nchecks++;
        if (rx_d[i] !== seg[8+i] || rx_l[i] !== (i == 5)) begin
          nfail++; $display("FAIL bp_beat%0d: d=%0d l=%b want %0d/%b", i, rx_d[i], rx_l[i], seg[8+i], i == 5);
        end
      end
    end
    nchecks++; if (nrd != 6) begin nfail++; $display("FAIL bp_nrd: got %0d want 6", nrd); end
    step(); w_ready = 1'b1;
  endtask

  task automatic test_zero_count();
    clear_log();
    kick(10'd5, 11'd0);
    @(negedge clk);
    nchecks++; if (done !== 1'b1 || busy !== 1'b1) begin nfail++; $display("FAIL zero_done: done=%b busy=%b want 1/1", done, busy); end
    @(negedge clk);
    nchecks++; if (done !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL zero_idle: done=%b busy=%b want 0/0", done, busy); end
    repeat (3) @(negedge clk);
    nchecks++; if (nrd != 0 || rx_d.size() != 0) begin nfail++; $display("FAIL zero_activity: reads=%0d beats=%0d want 0/0", nrd, rx_d.size()); end
    step();
  endtask

  task automatic test_reset_midblock();
    bit ok;
    clear_log(); w_ready = 1'b1;
    kick(10'd0, 11'd8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_d.size() >= 2) break;
    end
    step();
    rst = 1'b1; #1;
    nchecks++;
    if (mem_rd !== 1'b0 || mem_en !== 1'b0 || w_valid !== 1'b0 || w_last !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || w_data !== 14'sd0 || mem_index !== 10'd0) begin
      nfail++; $display("FAIL midrst_outputs: rd=%b v=%b busy=%b d=%0d idx=%0d want all 0", mem_rd, w_valid, busy, w_data, mem_index);
    end
    step(); step(); rst = 1'b0; step();
    clear_log();
    kick(10'd3, 11'd2);
    wait_done(ok);
    nchecks++; if (!ok) begin nfail++; $display("FAIL midrst_timeout: done not seen"); end
    nchecks++;
    if (rx_d.size() != 2 || nrd != 2) begin
      nfail++; $display("FAIL midrst_count: beats=%0d reads=%0d want 2/2", rx_d.size(), nrd);
    end else begin
      nchecks++;
      if (rx_d[0] !== 14'sd7 || rx_d[1] !== -14'sd56 || rx_l[0] !== 1'b0 || rx_l[1] !== 1'b1) begin
        nfail++; $display("FAIL midrst_data: %0d/%0d last %b%b want 7/-56 last 01", rx_d[0], rx_d[1], rx_l[0], rx_l[1]);
      end
    end
    step();
  endtask

  task automatic test_start_while_busy();
    bit ok;
    clear_log(); w_ready = 1'b1;
    kick(10'd16, 11'd3);
    start = 1'b1; base_addr = 10'd0; count = 11'd1;
    step();
    start = 1'b0;
    wait_done(ok);
    nchecks++; if (!ok) begin nfail++; $display("FAIL busy_timeout: done not seen"); end
    nchecks++;
    if (rx_d.size() != 3 || nrd != 3) begin
      nfail++; $display("FAIL busy_count: beats=%0d reads=%0d want 3/3", rx_d.size(), nrd);
    end else begin
      for (int i = 0; i < 3; i++) begin
        nchecks++;
        if (rx_d[i] !== seg[16+i] || idx_q[i] !== 10'(16+i)) begin
          nfail++; $display("FAIL busy_beat%0d: d=%0d idx=%0d want %0d/%0d", i, rx_d[i], idx_q[i], seg[16+i], 16+i);
        end
      end
    end
    repeat (3) @(negedge clk);
    nchecks++; if (busy !== 1'b0 || nrd != 3) begin nfail++; $display("FAIL busy_after: busy=%b reads=%0d want 0/3", busy, nrd); end
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) seg[i] = 14'(i * 11 - 100);
    seg[0] = 14'sd5; seg[1] = -14'sd3; seg[2] = 14'sd0; seg[3] = 14'sd7;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_reset_midblock();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end
endmodule
